// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for unified_mem_arbiter: fetch port, load/store port and memory port.
// master = arbiter side, slave = pipeline/memory environment side.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;
  logic              if_stall;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [2:0]        d_func3;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;
  logic              d_stall;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [2:0]        mem_func3;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              err;

  modport master (
    input  if_req, if_addr,
    output if_rdata, if_done, if_stall,
    input  d_req, d_we, d_addr, d_wdata, d_func3,
    output d_rdata, d_done, d_stall,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_func3,
    input  mem_rdata, mem_ready,
    output err
  );

  modport slave (
    output if_req, if_addr,
    input  if_rdata, if_done, if_stall,
    output d_req, d_we, d_addr, d_wdata, d_func3,
    input  d_rdata, d_done, d_stall,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_func3,
    output mem_rdata, mem_ready,
    input  err
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and load/store.
// Optional GRANT timeout with err pulse is compiled in with `define MEM_ARB_TIMEOUT_EN.
module unified_mem_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int MAX_STREAK = 4
`ifdef MEM_ARB_TIMEOUT_EN
  , parameter int TIMEOUT  = 15
`endif
) (
  input  logic clk,
  input  logic rst,
  unified_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, GRANT, RESP} state_t;

  localparam int SW = (MAX_STREAK > 0) ? $clog2(MAX_STREAK + 1) : 1;

  state_t        state, state_nxt;
  logic [SW-1:0] streak;
  logic          gnt_fetch;
  logic          fetch_win;
  logic          tmo_hit;

  // A waiting fetch overrides data priority once data has won MAX_STREAK times in a row.
  assign fetch_win = bus.if_req &&
                     (!bus.d_req || (MAX_STREAK != 0 && streak == SW'(MAX_STREAK)));

  assign bus.if_stall = bus.if_req & ~bus.if_done;
  assign bus.d_stall  = bus.d_req  & ~bus.d_done;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tmo_cnt;

  assign tmo_hit = (state == GRANT) && !bus.mem_ready && (tmo_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                tmo_cnt <= '0;
    else if (state != GRANT) tmo_cnt <= '0;
    else                     tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.if_req || bus.d_req)   state_nxt = GRANT;
      GRANT:   if (bus.mem_ready || tmo_hit)  state_nxt = RESP;
      RESP:                                   state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= {ADDR_W{1'b0}};
      bus.mem_wdata <= {DATA_W{1'b0}};
      bus.mem_func3 <= 3'b000;
      bus.if_rdata  <= {DATA_W{1'b0}};
      bus.d_rdata   <= {DATA_W{1'b0}};
      bus.if_done   <= 1'b0;
      bus.d_done    <= 1'b0;
      bus.err       <= 1'b0;
      streak        <= '0;
      gnt_fetch     <= 1'b0;
    end else begin
      bus.if_done <= 1'b0;
      bus.d_done  <= 1'b0;
      bus.err     <= 1'b0;
      case (state)
        IDLE: begin
          if (fetch_win) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= {DATA_W{1'b0}};
            bus.mem_func3 <= 3'b010;
            gnt_fetch     <= 1'b1;
            streak        <= '0;
          end else if (bus.d_req) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
            bus.mem_func3 <= bus.d_func3;
            gnt_fetch     <= 1'b0;
            if (!bus.if_req)                   streak <= '0;
            else if (streak != SW'(MAX_STREAK)) streak <= streak + 1'b1;
          end
        end
        GRANT: begin
          if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            if (gnt_fetch) begin
              bus.if_rdata <= bus.mem_rdata;
              bus.if_done  <= 1'b1;
            end else begin
              bus.d_rdata  <= bus.mem_rdata;
              bus.d_done   <= 1'b1;
            end
          end else if (tmo_hit) begin
            // Abandoned access completes with zero data so the pipeline can move on.
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            bus.err     <= 1'b1;
            if (gnt_fetch) begin
              bus.if_rdata <= {DATA_W{1'b0}};
              bus.if_done  <= 1'b1;
            end else begin
              bus.d_rdata  <= {DATA_W{1'b0}};
              bus.d_done   <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench for unified_mem_arbiter: directed accesses, a behavioural memory and a done monitor.
module tb_unified_mem_arbiter;

  typedef struct {
    bit          is_fetch;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  func3;
    logic [31:0] rdata;
    int          lat;
  } txn_t;

  logic clk;
  logic rst;
  logic model_ready;
  logic spurious_ready;
  int   cyc;
  int   ready_cyc;
  int   checks;
  int   passes;

  logic [31:0] mem [0:63];
  txn_t exp_mem[$];
  txn_t exp_rsp[$];
  txn_t f_list[$];
  txn_t d_list[$];
  txn_t mdl_t;
  txn_t mon_t;
  bit   aborted;

  unified_mem_arbiter_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  unified_mem_arbiter #(.ADDR_W(8), .DATA_W(32), .MAX_STREAK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.mem_ready = model_ready | spurious_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic txn_t mk(input bit f, input bit we, input logic [7:0] a,
                              input logic [31:0] wd, input logic [2:0] f3,
                              input logic [31:0] rd, input int lat);
    txn_t t;
    t.is_fetch = f;
    t.we       = we;
    t.addr     = a;
    t.wdata    = wd;
    t.func3    = f3;
    t.rdata    = rd;
    t.lat      = lat;
    return t;
  endfunction

  task automatic applyStimulus(input txn_t t);
    exp_mem.push_back(t);
    exp_rsp.push_back(t);
  endtask

  task automatic wait_done(input bit port);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = port ? bus.d_done : bus.if_done;
    end
    if (!seen) checkOutput(port ? "d_done_timeout" : "if_done_timeout", 32'd0, 32'd1);
  endtask

  task automatic fetch_stream();
    txn_t t;
    while (f_list.size() > 0) begin
      t = f_list.pop_front();
      bus.if_req  = 1'b1;
      bus.if_addr = t.addr;
      wait_done(1'b0);
    end
    bus.if_req = 1'b0;
  endtask

  task automatic data_stream();
    txn_t t;
    while (d_list.size() > 0) begin
      t = d_list.pop_front();
      bus.d_req   = 1'b1;
      bus.d_we    = t.we;
      bus.d_addr  = t.addr;
      bus.d_wdata = t.wdata;
      bus.d_func3 = t.func3;
      wait_done(1'b1);
    end
    bus.d_req = 1'b0;
  endtask

  // Memory model: checks each request against the expected grant order, holds it for lat cycles.
  initial begin
    model_ready   = 1'b0;
    bus.mem_rdata = 32'h0;
    ready_cyc     = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && bus.mem_req === 1'b1) begin
        if (exp_mem.size() == 0) begin
          checkOutput("unexpected_mem_req", 32'd1, 32'd0);
          mdl_t = mk(1'b0, 1'b0, bus.mem_addr, 32'h0, bus.mem_func3, 32'h0, 1);
        end else begin
          mdl_t = exp_mem.pop_front();
        end
        checkOutput("mem_we", 32'(bus.mem_we), 32'(mdl_t.we));
        checkOutput("mem_addr", 32'(bus.mem_addr), 32'(mdl_t.addr));
        checkOutput("mem_func3", 32'(bus.mem_func3), 32'(mdl_t.func3));
        if (mdl_t.we) checkOutput("mem_wdata", bus.mem_wdata, mdl_t.wdata);
        aborted = 1'b0;
        for (int i = 1; i < mdl_t.lat; i++) begin
          @(negedge clk);
          if (rst !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          checkOutput("grant_stable", {bus.mem_req, bus.mem_we, bus.mem_func3, bus.mem_addr},
                      {1'b1, mdl_t.we, mdl_t.func3, mdl_t.addr});
        end
        if (!aborted) begin
          bus.mem_rdata = mdl_t.we ? 32'h0 : mem[mdl_t.addr[7:2]];
          if (mdl_t.we) mem[mdl_t.addr[7:2]] = mdl_t.wdata;
          model_ready = 1'b1;
          ready_cyc   = cyc;
          @(negedge clk);
          model_ready = 1'b0;
          if (rst === 1'b1)
            checkOutput("resp_req_we_low", {30'd0, bus.mem_req, bus.mem_we}, 32'd0);
        end
      end
    end
  end

  // Done monitor: pops the expected response whenever either port completes.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && (bus.if_done === 1'b1 || bus.d_done === 1'b1)) begin
        if (exp_rsp.size() == 0) begin
          checkOutput("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_t = exp_rsp.pop_front();
          checkOutput("done_port", 32'(bus.if_done), 32'(mon_t.is_fetch));
          checkOutput("rdata", mon_t.is_fetch ? bus.if_rdata : bus.d_rdata, mon_t.rdata);
          checkOutput("done_latency", 32'(cyc - ready_cyc), 32'd1);
          checkOutput("err", 32'(bus.err), 32'd0);
        end
        if (bus.d_done === 1'b1 && bus.if_req === 1'b1)
          checkOutput("if_stall_held", 32'(bus.if_stall), 32'd1);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks         = 0;
    passes         = 0;
    spurious_ready = 1'b0;
    bus.if_req     = 1'b0;
    bus.if_addr    = 8'h0;
    bus.d_req      = 1'b0;
    bus.d_we       = 1'b0;
    bus.d_addr     = 8'h0;
    bus.d_wdata    = 32'h0;
    bus.d_func3    = 3'b000;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | i;
    mem[4] = 32'h0050_0093;
    mem[5] = 32'h00A0_0113;

    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_mem_req_we", {30'd0, bus.mem_req, bus.mem_we}, 32'd0);
    checkOutput("rst_mem_addr_func3", {21'd0, bus.mem_func3, bus.mem_addr}, 32'd0);
    checkOutput("rst_mem_wdata", bus.mem_wdata, 32'h0);
    checkOutput("rst_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
    checkOutput("rst_done_err", {29'd0, bus.if_done, bus.d_done, bus.err}, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    $display("[TB] fetch only");
    applyStimulus(mk(1'b1, 1'b0, 8'h10, 32'h0, 3'b010, 32'h0050_0093, 2));
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h10;
    #1 checkOutput("if_stall_c0", 32'(bus.if_stall), 32'd1);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      checkOutput("if_stall_wait", {30'd0, bus.if_stall, bus.if_done}, 32'd2);
    end
    @(negedge clk);
    checkOutput("if_done_c3", {30'd0, bus.if_stall, bus.if_done}, 32'd1);
    checkOutput("if_rdata_c3", bus.if_rdata, 32'h0050_0093);
    bus.if_req = 1'b0;

    $display("[TB] store");
    applyStimulus(mk(1'b0, 1'b1, 8'h20, 32'hDEAD_BEEF, 3'b010, 32'h0, 3));
    d_list.push_back(mk(1'b0, 1'b1, 8'h20, 32'hDEAD_BEEF, 3'b010, 32'h0, 3));
    data_stream();

    $display("[TB] starvation guard");
    applyStimulus(mk(1'b0, 1'b0, 8'h20, 32'h0, 3'b010, 32'hDEAD_BEEF, 1));
    applyStimulus(mk(1'b0, 1'b0, 8'h80, 32'h0, 3'b010, 32'h1000_0020, 2));
    applyStimulus(mk(1'b0, 1'b1, 8'h84, 32'h1234_5678, 3'b010, 32'h0, 1));
    applyStimulus(mk(1'b0, 1'b0, 8'h84, 32'h0, 3'b010, 32'h1234_5678, 1));
    applyStimulus(mk(1'b1, 1'b0, 8'h10, 32'h0, 3'b010, 32'h0050_0093, 1));
    applyStimulus(mk(1'b0, 1'b0, 8'h88, 32'h0, 3'b100, 32'h1000_0022, 1));
    applyStimulus(mk(1'b0, 1'b0, 8'h8C, 32'h0, 3'b010, 32'h1000_0023, 3));
    applyStimulus(mk(1'b0, 1'b0, 8'h90, 32'h0, 3'b001, 32'h1000_0024, 1));
    applyStimulus(mk(1'b0, 1'b0, 8'h94, 32'h0, 3'b010, 32'h1000_0025, 1));
    applyStimulus(mk(1'b1, 1'b0, 8'h14, 32'h0, 3'b010, 32'h00A0_0113, 2));
    for (int i = 0; i < exp_mem.size(); i++) begin
      if (exp_mem[i].is_fetch) f_list.push_back(exp_mem[i]);
      else                     d_list.push_back(exp_mem[i]);
    end
    fork
      fetch_stream();
      data_stream();
    join

    $display("[TB] simultaneous requests");
    applyStimulus(mk(1'b0, 1'b0, 8'h40, 32'h0, 3'b010, 32'h1000_0010, 1));
    applyStimulus(mk(1'b1, 1'b0, 8'h14, 32'h0, 3'b010, 32'h00A0_0113, 1));
    d_list.push_back(mk(1'b0, 1'b0, 8'h40, 32'h0, 3'b010, 32'h1000_0010, 1));
    f_list.push_back(mk(1'b1, 1'b0, 8'h14, 32'h0, 3'b010, 32'h00A0_0113, 1));
    fork
      fetch_stream();
      data_stream();
    join

    $display("[TB] reset mid-grant");
    exp_mem.push_back(mk(1'b1, 1'b0, 8'h10, 32'h0, 3'b010, 32'h0, 8));
    bus.if_req  = 1'b1;
    bus.if_addr = 8'h10;
    for (int i = 0; i < 20 && bus.mem_req !== 1'b1; i++) @(negedge clk);
    checkOutput("mem_req_seen", 32'(bus.mem_req), 32'd1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checkOutput("abort_mem_req_we", {30'd0, bus.mem_req, bus.mem_we}, 32'd0);
    checkOutput("abort_mem_addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("abort_rdata", bus.if_rdata | bus.d_rdata, 32'h0);
    checkOutput("abort_done_err", {29'd0, bus.if_done, bus.d_done, bus.err}, 32'd0);
    bus.if_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    spurious_ready = 1'b1;
    @(negedge clk);
    spurious_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("post_abort_quiet", {29'd0, bus.mem_req, bus.if_done, bus.d_done}, 32'd0);
    end
    checkOutput("post_abort_if_rdata", bus.if_rdata, 32'h0);

    checkOutput("exp_mem_drain", 32'(exp_mem.size()), 32'd0);
    checkOutput("exp_rsp_drain", 32'(exp_rsp.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
